// File: rtl/load_store_unit.sv
// load_store_unit: runs one req/ack data-memory transaction per load/store and stalls the core until it completes or faults.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        isLoad,
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic [31:0] loadData,
  output logic        stall,
  output logic        done,
  output logic        misaligned,
  output logic        busError,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;
  state_t state, state_n;
  logic [15:0] cnt;
  logic [2:0] f3_q;
  logic [1:0] lane_q;
  logic [31:0] load_q, wdata_n, shifted, ext;
  logic [3:0] wstrb_n;
  logic [15:0] half;
  logic bus_err_q, op, fault, timeout, we_n;
  assign op = start & (isLoad | isStore);
  assign we_n = isStore & ~isLoad;
  assign fault = funct3 == 3'b011 || funct3[2:1] == 2'b11 ||
                 (funct3[1:0] == 2'b01 && addr[0]) ||
                 (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  assign timeout = cnt == 16'(TIMEOUT_CYCLES - 1);
  assign wdata_n = funct3[1:0] == 2'b00 ? {4{storeData[7:0]}} :
                   funct3[1:0] == 2'b01 ? {2{storeData[15:0]}} : storeData;
  assign wstrb_n = !we_n ? 4'b0000 :
                   funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                   funct3[1:0] == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
  assign shifted = mem_rdata >> {lane_q, 3'b000};
  assign half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign ext = f3_q[1] ? mem_rdata :
               f3_q[0] ? {{16{~f3_q[2] & half[15]}}, half} :
                         {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
  always_comb begin
    state_n = state == IDLE ? (!op ? IDLE : fault ? FAULT : REQ) :
              state == REQ  ? ((mem_ack || timeout) ? DONE : REQ) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      f3_q      <= '0;
      lane_q    <= '0;
      load_q    <= '0;
      bus_err_q <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      state <= state_n;
      cnt   <= state == REQ ? cnt + 16'd1 : '0;
      if (state == IDLE && op && !fault) begin
        f3_q      <= funct3;
        lane_q    <= addr[1:0];
        mem_we    <= we_n;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_wdata <= wdata_n;
        mem_wstrb <= wstrb_n;
      end
      // ack on the final timeout cycle still counts as a successful access
      if (state == REQ) begin
        load_q    <= mem_ack ? ext : '0;
        bus_err_q <= ~mem_ack & timeout;
      end
    end
  end
  assign mem_req    = state == REQ;
  assign stall      = (state == IDLE && op) || state == REQ;
  assign done       = state == DONE || state == FAULT;
  assign misaligned = state == FAULT;
  assign busError   = state == DONE && bus_err_q;
  assign loadData   = state == DONE ? load_q : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized load/store transactions checked against a behavioural model.
module tb_load_store_unit;
  localparam int T = 8;
  logic clk = 0, reset = 1, start = 0, isLoad = 0, isStore = 0, mem_ack = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, storeData = 0, mem_rdata = 0;
  logic [31:0] loadData, mem_addr, mem_wdata;
  logic stall, done, misaligned, busError, mem_req, mem_we;
  logic [3:0] mem_wstrb;
  int n_cmp = 0, n_bad = 0;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .start(start), .isLoad(isLoad), .isStore(isStore),
    .funct3(funct3), .addr(addr), .storeData(storeData), .loadData(loadData),
    .stall(stall), .done(done), .misaligned(misaligned), .busError(busError),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rd, input int ack_at);
    logic flt, acked;
    logic [31:0] e_ld, e_wd;
    logic [3:0] e_ws;
    logic [7:0] b, sb;
    logic [15:0] h, sh;
    int lane;
    lane = int'(a[1:0]);
    flt = f3 == 3 || f3 == 6 || f3 == 7 || ((f3 == 1 || f3 == 5) && lane % 2 == 1) ||
          (f3 == 2 && lane != 0);
    b = 8'(rd >> (8 * lane));
    h = 16'(rd >> (16 * (lane / 2)));
    sb = sd[7:0];
    sh = sd[15:0];
    case (f3)
      3'd0: e_ld = {{24{b[7]}}, b};
      3'd1: e_ld = {{16{h[15]}}, h};
      3'd4: e_ld = {24'd0, b};
      3'd5: e_ld = {16'd0, h};
      default: e_ld = rd;
    endcase
    e_wd = f3 == 0 ? sb * 32'h01010101 : f3 == 1 ? sh * 32'h00010001 : sd;
    e_ws = ld ? 4'd0 : f3 == 0 ? 4'(1 << lane) : f3 == 1 ? 4'(3 << lane) : 4'hF;
    @(negedge clk);
    start = 1; isLoad = ld; isStore = st; funct3 = f3; addr = a; storeData = sd; mem_ack = 0;
    #1;
    check("stall_on_op", stall, 1);
    check("no_done_on_op", done, 0);
    if (flt) begin
      @(negedge clk);
      check("fault_done", done, 1);
      check("fault_misaligned", misaligned, 1);
      check("fault_buserr", busError, 0);
      check("fault_loaddata", loadData, 0);
      check("fault_no_req", mem_req, 0);
      check("fault_stall", stall, 0);
      start = 0;
      return;
    end
    acked = 0;
    for (int k = 0; k < T && !acked; k++) begin
      @(negedge clk);
      mem_ack = 0; mem_rdata = $urandom;
      #1;
      check("req_high", mem_req, 1);
      check("req_stall", stall, 1);
      check("req_no_done", done, 0);
      check("req_addr", mem_addr, {a[31:2], 2'b00});
      check("req_wstrb", mem_wstrb, e_ws);
      if (k == 0) begin
        check("req_we", mem_we, !ld);
        if (!ld) check("req_wdata", mem_wdata, e_wd);
      end
      if (k == ack_at) begin
        mem_ack = 1; mem_rdata = rd; acked = 1;
      end
    end
    @(negedge clk);
    mem_ack = 0;
    #1;
    check("done_pulse", done, 1);
    check("done_stall", stall, 0);
    check("done_misaligned", misaligned, 0);
    check("done_buserr", busError, !acked);
    check("done_req_low", mem_req, 0);
    if (ld || !acked) check("done_loaddata", loadData, acked ? e_ld : 0);
    start = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_ack = 1'($urandom); mem_rdata = $urandom;
      #1;
      check("idle_no_done", done, 0);
      check("idle_no_req", mem_req, 0);
    end
    mem_ack = 0;
  endtask

  initial begin
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] rsv [3] = '{3'd3, 3'd6, 3'd7};
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] ld_f3 [5];
    logic [2:0] rsv [3];
    logic ld, st;
    logic [2:0] f3;
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rsv = '{3'd3, 3'd6, 3'd7};
    repeat (2) @(negedge clk);
    check("rst_req", mem_req, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall, 0);
    check("rst_loaddata", loadData, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wstrb", mem_wstrb, 0);
    check("rst_flags", {misaligned, busError, mem_we}, 0);
    reset = 0;
    idle_cycles(2);
    do_op(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 1);
    do_op(1, 0, 3'd0, 32'h103, 0, 32'h80123456, 0);
    do_op(1, 0, 3'd4, 32'h103, 0, 32'h80123456, 0);
    do_op(0, 1, 3'd1, 32'h102, 32'h00001234, 0, 0);
    do_op(1, 0, 3'd2, 32'h101, 0, 0, 0);
    do_op(1, 0, 3'd3, 32'h100, 0, 0, 0);
    do_op(1, 0, 3'd2, 32'h200, 0, 0, 99);
    do_op(1, 1, 3'd5, 32'h042, 32'h55AA55AA, 32'hBEEF1234, 7);
    idle_cycles(3);
    @(negedge clk);
    start = 1; isLoad = 1; isStore = 0; funct3 = 3'd2; addr = 32'h300;
    @(negedge clk);
    check("rst_test_req", mem_req, 1);
    @(negedge clk);
    reset = 1; start = 0;
    @(negedge clk);
    check("rst_mid_req_low", mem_req, 0);
    check("rst_mid_no_done", done, 0);
    reset = 0;
    idle_cycles(2);
    do_op(1, 0, 3'd2, 32'h300, 0, 32'hCAFEF00D, 2);
    for (int i = 0; i < 200; i++) begin
      ld = 1'($urandom);
      st = ld ? 1'($urandom) : 1'b1;
      f3 = $urandom_range(0, 7) == 0 ? rsv[$urandom_range(0, 2)] :
           ld ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      do_op(ld, st, f3, $urandom, $urandom, $urandom, $urandom_range(0, 9));
      idle_cycles($urandom_range(0, 2));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
